// File: rtl/gcn_aggregation_block.sv
// gcn_aggregation_block
//   GCN aggregation stage. Once start is seen in IDLE, it snapshots the
//   transformation product matrix FM_WM_Row and uses each node's own row as
//   that node's starting accumulator. It then walks a COO edge list, one edge
//   per cycle, and adds each endpoint's row into the other endpoint's
//   accumulator. Finally it reduces every accumulated row to a class index by
//   unsigned argmax; ties go to the lowest column.
//
// Ports
//   clk             : single clock, rising edge
//   reset           : synchronous, active-high
//   start           : level start (transformation done_trans), only seen in IDLE
//   FM_WM_Row       : [NUM_OF_NODES][WEIGHT_COLS] unsigned product matrix
//   coo_address     : edge index presented to the edge memory
//   enable_read_coo : edge memory read enable (high for NUM_OF_EDGES cycles)
//   coo_in          : {src, dst} of the addressed edge, same-cycle valid
//   y               : argmax class per node
//   done            : result valid, held until start drops
//   err_edge        : sticky, set when an out-of-range edge was skipped
module gcn_aggregation_block #(
  parameter int NUM_OF_NODES      = 6,
  parameter int WEIGHT_COLS       = 3,
  parameter int DOT_PROD_WIDTH    = 16,
  parameter int NUM_OF_EDGES      = 6,
  parameter int NODE_WIDTH        = $clog2(NUM_OF_NODES) + 1,
  parameter int AGG_WIDTH         = 19,
  parameter int COO_ADDRESS_WIDTH = $clog2(NUM_OF_EDGES),
  parameter int CLASS_WIDTH       = $clog2(WEIGHT_COLS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [DOT_PROD_WIDTH-1:0]    FM_WM_Row [0:NUM_OF_NODES-1][0:WEIGHT_COLS-1],
  output logic [COO_ADDRESS_WIDTH-1:0] coo_address,
  output logic                         enable_read_coo,
  input  logic [NODE_WIDTH-1:0]        coo_in [0:1],
  output logic [CLASS_WIDTH-1:0]       y [0:NUM_OF_NODES-1],
  output logic                         done,
  output logic                         err_edge
);

  localparam int NIW = $clog2(NUM_OF_NODES);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    READ,
    ARGMAX,
    DONE
  } state_t;

  state_t                       state_q, state_d;
  logic [AGG_WIDTH-1:0]         agg_q [0:NUM_OF_NODES-1][0:WEIGHT_COLS-1];
  logic [AGG_WIDTH-1:0]         agg_d [0:NUM_OF_NODES-1][0:WEIGHT_COLS-1];
  logic [DOT_PROD_WIDTH-1:0]    fm_q  [0:NUM_OF_NODES-1][0:WEIGHT_COLS-1];
  logic [DOT_PROD_WIDTH-1:0]    fm_d  [0:NUM_OF_NODES-1][0:WEIGHT_COLS-1];
  logic [CLASS_WIDTH-1:0]       y_q   [0:NUM_OF_NODES-1];
  logic [CLASS_WIDTH-1:0]       y_d   [0:NUM_OF_NODES-1];
  logic [COO_ADDRESS_WIDTH-1:0] edge_q, edge_d;
  logic [NIW-1:0]               node_q, node_d;
  logic                         done_q, done_d;
  logic                         err_q, err_d;

  // Edge decode
  logic [NODE_WIDTH-1:0] src, dst;
  logic [NIW-1:0]        src_idx, dst_idx;
  logic                  edge_in_range;

  // Argmax over the row selected by node_q
  logic [AGG_WIDTH-1:0]   best_val;
  logic [CLASS_WIDTH-1:0] best_idx;

  assign src           = coo_in[0];
  assign dst           = coo_in[1];
  assign src_idx       = src[NIW-1:0];
  assign dst_idx       = dst[NIW-1:0];
  assign edge_in_range = (src < NODE_WIDTH'(NUM_OF_NODES)) &&
                         (dst < NODE_WIDTH'(NUM_OF_NODES));

  always_comb begin
    best_val = agg_q[node_q][0];
    best_idx = '0;
    // Strict compare keeps the lowest column on ties.
    for (int unsigned c = 1; c < WEIGHT_COLS; c++) begin
      if (agg_q[node_q][c] > best_val) begin
        best_val = agg_q[node_q][c];
        best_idx = CLASS_WIDTH'(c);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    agg_d   = agg_q;
    fm_d    = fm_q;
    y_d     = y_q;
    edge_d  = edge_q;
    node_d  = node_q;
    done_d  = done_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = INIT;
          err_d   = 1'b0;
        end
      end

      INIT: begin
        // The matrix is captured here, and the edge walk reads the captured copy.
        for (int unsigned n = 0; n < NUM_OF_NODES; n++) begin
          for (int unsigned c = 0; c < WEIGHT_COLS; c++) begin
            fm_d[n][c]  = FM_WM_Row[n][c];
            agg_d[n][c] = AGG_WIDTH'(FM_WM_Row[n][c]);
          end
        end
        edge_d  = '0;
        state_d = READ;
      end

      READ: begin
        if (!edge_in_range) begin
          err_d = 1'b1;
        end else if (src != dst) begin
          for (int unsigned c = 0; c < WEIGHT_COLS; c++) begin
            agg_d[src_idx][c] = agg_q[src_idx][c] + AGG_WIDTH'(fm_q[dst_idx][c]);
            agg_d[dst_idx][c] = agg_q[dst_idx][c] + AGG_WIDTH'(fm_q[src_idx][c]);
          end
        end
        if (edge_q == COO_ADDRESS_WIDTH'(NUM_OF_EDGES - 1)) begin
          node_d  = '0;
          state_d = ARGMAX;
        end else begin
          edge_d = edge_q + COO_ADDRESS_WIDTH'(1);
        end
      end

      ARGMAX: begin
        y_d[node_q] = best_idx;
        if (node_q == NIW'(NUM_OF_NODES - 1)) begin
          state_d = DONE;
        end else begin
          node_d = node_q + NIW'(1);
        end
      end

      DONE: begin
        // done is registered. It rises on the first DONE cycle and is always
        // shown for at least one cycle before the block may return to IDLE.
        done_d = 1'b1;
        if (done_q && !start) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      agg_q   <= '{default: '{default: '0}};
      fm_q    <= '{default: '{default: '0}};
      y_q     <= '{default: '0};
      edge_q  <= '0;
      node_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      agg_q   <= agg_d;
      fm_q    <= fm_d;
      y_q     <= y_d;
      edge_q  <= edge_d;
      node_q  <= node_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign enable_read_coo = (state_q == READ);
  assign coo_address     = (state_q == READ) ? edge_q : '0;
  assign y               = y_q;
  assign done            = done_q;
  assign err_edge        = err_q;

endmodule

// File: tb/tb_gcn_aggregation_block.sv
module tb_gcn_aggregation_block;

  localparam int N  = 6;
  localparam int C  = 3;
  localparam int E  = 6;
  localparam int LAT = 2 + E + N;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] fm [0:N-1][0:C-1];
  logic [2:0]  coo_address;
  logic        enable_read_coo;
  logic [3:0]  coo_in [0:1];
  logic [1:0]  y [0:N-1];
  logic        done;
  logic        err_edge;

  int e_src [0:E-1];
  int e_dst [0:E-1];

  int vec = 0;
  int bad = 0;

  gcn_aggregation_block #(
    .NUM_OF_NODES(N),
    .WEIGHT_COLS(C),
    .DOT_PROD_WIDTH(16),
    .NUM_OF_EDGES(E)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .FM_WM_Row(fm),
    .coo_address(coo_address),
    .enable_read_coo(enable_read_coo),
    .coo_in(coo_in),
    .y(y),
    .done(done),
    .err_edge(err_edge)
  );

  always #5 clk = ~clk;

  // Combinational edge memory
  always_comb begin
    int k;
    k = int'(coo_address);
    if (k < E) begin
      coo_in[0] = 4'(e_src[k]);
      coo_in[1] = 4'(e_dst[k]);
    end else begin
      coo_in[0] = '0;
      coo_in[1] = '0;
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    vec++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // cyc counts rising edges after the edge that accepted start.
  bit m_busy = 0, m_done = 0, m_err = 0, m_live = 0;
  int cyc = 0;
  int m_y [0:N-1];
  int exp_y [0:N-1];
  bit edge_bad [0:E-1];

  always @(posedge clk) begin
    m_live = 1;
    if (reset) begin
      m_busy = 0; m_done = 0; m_err = 0; cyc = 0;
      for (int n = 0; n < N; n++) m_y[n] = 0;
    end else if (m_busy) begin
      cyc++;
      if (cyc == 1) begin
        int agg [0:N-1][0:C-1];
        for (int n = 0; n < N; n++)
          for (int c = 0; c < C; c++) agg[n][c] = int'(fm[n][c]);
        for (int k = 0; k < E; k++) begin
          edge_bad[k] = !(e_src[k] < N && e_dst[k] < N);
          if (!edge_bad[k] && e_src[k] != e_dst[k])
            for (int c = 0; c < C; c++) begin
              agg[e_src[k]][c] += int'(fm[e_dst[k]][c]);
              agg[e_dst[k]][c] += int'(fm[e_src[k]][c]);
            end
        end
        for (int n = 0; n < N; n++) begin
          exp_y[n] = 0;
          for (int c = 1; c < C; c++)
            if (agg[n][c] > agg[n][exp_y[n]]) exp_y[n] = c;
        end
      end
      if (cyc >= 2 && cyc <= E + 1 && edge_bad[cyc-2]) m_err = 1;
      if (cyc == LAT) begin
        m_busy = 0; m_done = 1;
        for (int n = 0; n < N; n++) m_y[n] = exp_y[n];
      end
    end else if (m_done) begin
      if (!start) m_done = 0;
    end else if (start) begin
      m_busy = 1; cyc = 0; m_err = 0;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (m_live) begin
      bit exp_en;
      exp_en = m_busy && cyc >= 1 && cyc <= E;
      chk("done", int'(done), int'(m_done));
      chk("err_edge", int'(err_edge), int'(m_err));
      chk("enable_read_coo", int'(enable_read_coo), int'(exp_en));
      if (exp_en) chk("coo_address", int'(coo_address), cyc - 1);
      if (!m_busy)
        for (int n = 0; n < N; n++) chk($sformatf("y[%0d]", n), int'(y[n]), m_y[n]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_identity();
    for (int n = 0; n < N; n++)
      for (int c = 0; c < C; c++) fm[n][c] = (c == n % 3) ? 16'd50 : 16'd0;
    for (int k = 0; k < E; k++) begin e_src[k] = k; e_dst[k] = k; end
  endtask

  task automatic run_and_wait(output int lat);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
  endtask

  task automatic drop_start();
    start = 1'b0;
    @(posedge clk); #1;
    chk("done_after_drop", int'(done), 0);
  endtask

  task automatic chk_y(input string nm, input int e0, input int e1, input int e2,
                       input int e3, input int e4, input int e5);
    int ev [0:N-1];
    ev = '{e0, e1, e2, e3, e4, e5};
    for (int n = 0; n < N; n++) chk($sformatf("%s y[%0d]", nm, n), int'(y[n]), ev[n]);
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    start = 1'b0;
    set_identity();
    repeat (3) @(posedge clk);
    #1;
    chk("reset done", int'(done), 0);
    chk("reset err_edge", int'(err_edge), 0);
    chk("reset enable_read_coo", int'(enable_read_coo), 0);
    chk("reset coo_address", int'(coo_address), 0);
    chk_y("reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: identity
    set_identity();
    run_and_wait(lat);
    chk("t1 latency", lat, LAT);
    chk_y("t1", 0, 1, 2, 0, 1, 2);
    chk("t1 err_edge", int'(err_edge), 0);
    drop_start();

    // 2: neighbour sum
    for (int n = 0; n < N; n++) for (int c = 0; c < C; c++) fm[n][c] = '0;
    fm[0][2] = 16'd40;
    fm[1][0] = 16'd30;
    e_src[0] = 0; e_dst[0] = 1;
    for (int k = 1; k < E; k++) begin e_src[k] = 5; e_dst[k] = 5; end
    run_and_wait(lat);
    chk("t2 latency", lat, LAT);
    chk_y("t2", 2, 2, 0, 0, 0, 0);
    drop_start();

    // 3: ties on a ring
    for (int n = 0; n < N; n++) for (int c = 0; c < C; c++) fm[n][c] = 16'd7;
    for (int k = 0; k < E; k++) begin e_src[k] = k; e_dst[k] = (k + 1) % N; end
    run_and_wait(lat);
    chk_y("t3", 0, 0, 0, 0, 0, 0);
    drop_start();

    // 4: out-of-range edge
    set_identity();
    e_src[2] = 6; e_dst[2] = 2;
    run_and_wait(lat);
    chk_y("t4", 0, 1, 2, 0, 1, 2);
    chk("t4 err_edge", int'(err_edge), 1);
    drop_start();
    repeat (3) @(posedge clk);
    #1 chk("t4 err_edge held", int'(err_edge), 1);

    // 5: reset during the third READ cycle, then rerun
    set_identity();
    @(posedge clk); #1 start = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    chk("t5 done", int'(done), 0);
    chk("t5 enable_read_coo", int'(enable_read_coo), 0);
    chk("t5 err_edge", int'(err_edge), 0);
    chk_y("t5", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    run_and_wait(lat);
    chk("t5 latency", lat, LAT);
    chk_y("t5 rerun", 0, 1, 2, 0, 1, 2);

    // 6: hold start after done, then release
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("t6 done held", int'(done), 1);
    end
    drop_start();
    chk_y("t6", 0, 1, 2, 0, 1, 2);
    repeat (3) @(posedge clk);
    #1 chk("t6 idle done", int'(done), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
